// File: rtl/reg_writeback_pkg.sv
// Shared definitions for the register-file write-port sequencer.
//   NUM_REGS : number of architectural registers (r0..r15)
//   RW       : register-number width, fixed by the 16-entry register file
//   state_t  : sequencer state (CLEAR sweep after reset, RUN normal operation)
package reg_writeback_pkg;

  localparam int NUM_REGS = 16;
  localparam int RW       = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Core <-> write-port sequencer signal bundle.
//   master : core side (drives ALU results, load issue/return, source regs;
//            observes the register-file write port, hazard and busy)
//   slave  : sequencer side (reg_writeback)
// Signals:
//   alu_we/alu_rd/alu_res    single-cycle ALU result
//   ld_issue/ld_rd           load issued, destination register
//   ld_valid/ld_data         load data return
//   rs_a/rs_b/rs_c           source registers read this cycle
//   rf_wr/rf_adr/rf_din      register file write port
//   hazard                   source or ALU destination hits the pending load
//   busy                     core must not issue
interface reg_writeback_if #(
  parameter int DW = 32
);
  import reg_writeback_pkg::*;

  logic          alu_we;
  logic [RW-1:0] alu_rd;
  logic [DW-1:0] alu_res;
  logic          ld_issue;
  logic [RW-1:0] ld_rd;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic [RW-1:0] rs_a;
  logic [RW-1:0] rs_b;
  logic [RW-1:0] rs_c;
  logic          rf_wr;
  logic [RW-1:0] rf_adr;
  logic [DW-1:0] rf_din;
  logic          hazard;
  logic          busy;

  modport master (
    output alu_we, alu_rd, alu_res,
    output ld_issue, ld_rd, ld_valid, ld_data,
    output rs_a, rs_b, rs_c,
    input  rf_wr, rf_adr, rf_din, hazard, busy
  );

  modport slave (
    input  alu_we, alu_rd, alu_res,
    input  ld_issue, ld_rd, ld_valid, ld_data,
    input  rs_a, rs_b, rs_c,
    output rf_wr, rf_adr, rf_din, hazard, busy
  );

endinterface

// File: rtl/reg_writeback.sv
// Write-port sequencer for the 16x32 triple-port register file.
// Owns rf_wr/rf_adr/rf_din. After reset it sweeps zeros into r0..r15, then
// merges single-cycle ALU results and one outstanding load return into the
// single write port. Load return has priority; a colliding ALU result is held
// in a one-entry skid and written on the next free cycle.
// Ports:
//   clk  core clock, rising edge
//   rst  synchronous reset, active-high
//   bus  reg_writeback_if.slave (ALU/load inputs, source regs, write port,
//        hazard, busy)
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = NUM_REGS
) (
  input logic             clk,
  input logic             rst,
  reg_writeback_if.slave  bus
);

  state_t        state_q;
  state_t        state_d;
  logic [RW-1:0] cnt_q;

  logic          pend_q;
  logic [RW-1:0] ld_rd_q;

  logic          skid_v;
  logic [RW-1:0] skid_rd;
  logic [DW-1:0] skid_dat;

  logic          run;
  logic          ld_fire;
  logic          src_hit;

  assign run     = (state_q == RUN);
  // A return with no load outstanding is ignored (and flagged below).
  assign ld_fire = run & bus.ld_valid & pend_q;

  assign src_hit = (bus.rs_a == ld_rd_q) | (bus.rs_b == ld_rd_q) |
                   (bus.rs_c == ld_rd_q) | (bus.alu_we & (bus.alu_rd == ld_rd_q));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == RW'(NREG - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Sweep address counter
  always_ff @(posedge clk) begin
    if (rst)                     cnt_q <= '0;
    else if (state_q == CLEAR)   cnt_q <= cnt_q + 1'b1;
  end

  // Pending-load scoreboard. A same-cycle issue wins over the return so a
  // back-to-back load keeps the slot occupied with the new destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      ld_rd_q <= '0;
    end else if (run) begin
      if (bus.ld_issue) begin
        pend_q  <= 1'b1;
        ld_rd_q <= bus.ld_rd;
      end else if (ld_fire) begin
        pend_q  <= 1'b0;
      end
    end
  end

  // One-entry ALU skid. Fills when an ALU write loses to a load return;
  // drains on the next cycle without a load return. An ALU result arriving
  // during a drain replaces the entry, preserving write order.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_v   <= 1'b0;
      skid_rd  <= '0;
      skid_dat <= '0;
    end else if (run) begin
      if (ld_fire) begin
        if (bus.alu_we && !skid_v) begin
          skid_v   <= 1'b1;
          skid_rd  <= bus.alu_rd;
          skid_dat <= bus.alu_res;
        end
      end else if (skid_v) begin
        skid_v   <= bus.alu_we;
        skid_rd  <= bus.alu_rd;
        skid_dat <= bus.alu_res;
      end
    end
  end

  // Outputs: write port, busy and hazard are combinational from state+inputs
  always_comb begin
    bus.rf_wr  = 1'b0;
    bus.rf_adr = '0;
    bus.rf_din = '0;
    bus.busy   = 1'b1;
    bus.hazard = 1'b0;
    if (!rst) begin
      case (state_q)
        CLEAR: begin
          bus.rf_wr  = 1'b1;
          bus.rf_adr = cnt_q;
          bus.busy   = 1'b1;
        end
        RUN: begin
          if (ld_fire) begin
            bus.rf_wr  = 1'b1;
            bus.rf_adr = ld_rd_q;
            bus.rf_din = bus.ld_data;
          end else if (skid_v) begin
            bus.rf_wr  = 1'b1;
            bus.rf_adr = skid_rd;
            bus.rf_din = skid_dat;
          end else if (bus.alu_we) begin
            bus.rf_wr  = 1'b1;
            bus.rf_adr = bus.alu_rd;
            bus.rf_din = bus.alu_res;
          end
          bus.busy   = skid_v | (pend_q & ~bus.ld_valid);
          // The returning data lands on this edge, so no stall is needed.
          bus.hazard = pend_q & ~bus.ld_valid & src_hit;
        end
        default: ;
      endcase
    end
  end

  // Protocol checks
  a_alu_while_busy: assert property (@(posedge clk) disable iff (rst)
    (run && bus.alu_we) |-> !bus.busy);
  a_ld_while_busy: assert property (@(posedge clk) disable iff (rst)
    (run && bus.ld_issue) |-> !bus.busy);
  a_orphan_return: assert property (@(posedge clk) disable iff (rst)
    (run && bus.ld_valid) |-> pend_q);

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback. Expected register-file writes are
// queued in the cycle they are due; a negedge monitor compares every cycle's
// write port against the queue (an empty slot means no write allowed).
module tb_reg_writeback;

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] dat;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic mon_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  reg_writeback_if #(.DW(32)) bus ();

  reg_writeback #(.DW(32), .NREG(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.alu_we   = 1'b0;
    bus.alu_rd   = '0;
    bus.alu_res  = '0;
    bus.ld_issue = 1'b0;
    bus.ld_rd    = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.rs_a     = '0;
    bus.rs_b     = '0;
    bus.rs_c     = '0;
  endtask

  task automatic expect_wr(input logic [3:0] adr, input logic [31:0] dat);
    wr_t e;
    e.adr = adr;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      chk("rf_wr", 32'(bus.rf_wr), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (bus.rf_wr === 1'b1) begin
          chk("rf_adr", 32'(bus.rf_adr), 32'(e.adr));
          chk("rf_din", bus.rf_din, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    next_cycle();
    mon_en = 1'b1;

    // Reset held: no write, busy, no hazard
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_hazard", 32'(bus.hazard), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Zero sweep r0..r15
    for (int i = 0; i < 16; i++) begin
      expect_wr(4'(i), 32'h0);
      @(negedge clk);
      chk("clr_busy", 32'(bus.busy), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    chk("run_busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // Plain ALU write, zero latency
    bus.alu_we = 1'b1; bus.alu_rd = 4'd3; bus.alu_res = 32'h1234_5678;
    expect_wr(4'd3, 32'h1234_5678);
    @(negedge clk);
    chk("alu_busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // Full-width data to the top register
    idle();
    bus.alu_we = 1'b1; bus.alu_rd = 4'd15; bus.alu_res = 32'hFFFF_FFFF;
    expect_wr(4'd15, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("alu15_busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // Load to r5, hazard on rs_b, clean return
    idle();
    bus.ld_issue = 1'b1; bus.ld_rd = 4'd5;
    @(negedge clk);
    chk("ldiss_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    idle();
    bus.rs_b = 4'd5;
    @(negedge clk);
    chk("ld_hazard", 32'(bus.hazard), 32'd1);
    chk("ld_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    idle();
    bus.rs_a = 4'd7; bus.rs_b = 4'd6; bus.rs_c = 4'd4;
    @(negedge clk);
    chk("nohit_hazard", 32'(bus.hazard), 32'd0);
    chk("nohit_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    idle();
    bus.ld_valid = 1'b1; bus.ld_data = 32'hCAFE_F00D; bus.rs_b = 4'd5;
    expect_wr(4'd5, 32'hCAFE_F00D);
    @(negedge clk);
    chk("ret_hazard", 32'(bus.hazard), 32'd0);
    chk("ret_busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // Load return collides with ALU write: ALU goes through the skid
    idle();
    bus.ld_issue = 1'b1; bus.ld_rd = 4'd5;
    next_cycle();
    idle();
    bus.ld_valid = 1'b1; bus.ld_data = 32'h55AA_55AA;
    bus.alu_we = 1'b1; bus.alu_rd = 4'd2; bus.alu_res = 32'h77;
    expect_wr(4'd5, 32'h55AA_55AA);
    @(negedge clk);
    chk("coll_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    idle();
    expect_wr(4'd2, 32'h77);
    @(negedge clk);
    chk("skid_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("post_skid_busy", 32'(bus.busy), 32'd0);
    next_cycle();

    // Back-to-back loads: r5 returns while r9 issues
    bus.ld_issue = 1'b1; bus.ld_rd = 4'd5;
    next_cycle();
    idle();
    bus.ld_valid = 1'b1; bus.ld_data = 32'h0BAD_F00D;
    bus.ld_issue = 1'b1; bus.ld_rd = 4'd9;
    expect_wr(4'd5, 32'h0BAD_F00D);
    @(negedge clk);
    chk("b2b_busy", 32'(bus.busy), 32'd0);
    next_cycle();
    idle();
    bus.rs_a = 4'd9;
    @(negedge clk);
    chk("b2b_hazard", 32'(bus.hazard), 32'd1);
    chk("b2b_pend_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    idle();
    bus.ld_valid = 1'b1; bus.ld_data = 32'h9999_0009; bus.rs_a = 4'd9;
    expect_wr(4'd9, 32'h9999_0009);
    @(negedge clk);
    chk("b2b_ret_hazard", 32'(bus.hazard), 32'd0);
    next_cycle();

    // Reset with skid full and a load pending
    idle();
    bus.ld_issue = 1'b1; bus.ld_rd = 4'd4;
    next_cycle();
    idle();
    bus.ld_valid = 1'b1; bus.ld_data = 32'hA5A5_0004;
    bus.alu_we = 1'b1; bus.alu_rd = 4'd2; bus.alu_res = 32'h88;
    bus.ld_issue = 1'b1; bus.ld_rd = 4'd5;
    expect_wr(4'd4, 32'hA5A5_0004);
    next_cycle();
    idle();
    rst = 1'b1;
    bus.rs_a = 4'd5;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    chk("mid_rst_hazard", 32'(bus.hazard), 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.ld_valid = (i == 3);
      bus.ld_data  = 32'hDEAD_BEEF;
      expect_wr(4'(i), 32'h0);
      @(negedge clk);
      chk("resweep_busy", 32'(bus.busy), 32'd1);
      next_cycle();
    end
    idle();
    bus.rs_a = 4'd5; bus.rs_b = 4'd5;
    @(negedge clk);
    chk("rerun_busy", 32'(bus.busy), 32'd0);
    chk("rerun_hazard", 32'(bus.hazard), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    next_cycle();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
